// File: rtl/ps2_key_tx.sv
// PS/2 device-side keyboard transmitter: turns make/break key events into framed scan-code bytes.
// Define PS2_EXT_KEY_EN to add the key_ext input and the 0xE0 extended-key prefix.
`timescale 1ns/1ps
module ps2_key_tx #(
    parameter int unsigned CLK_DIV    = 50,
    parameter int unsigned GAP_HALVES = 2
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       key_release,
`ifdef PS2_EXT_KEY_EN
    input  logic       key_ext,
`endif
    output logic       key_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {StIdle, StBitHi, StBitLo, StGap} state_e;

    localparam logic [15:0] HalfLast  = 16'(CLK_DIV - 1);
    localparam int unsigned GapCycles = GAP_HALVES * CLK_DIV;
    localparam logic [15:0] GapLast   = (GapCycles == 0) ? 16'd0 : 16'(GapCycles - 1);

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic [2:0][7:0] seq_q, seq_d;
    logic [1:0]      left_q, left_d;
    logic            ps2_clk_q, ps2_clk_d;
    logic            ps2_data_q, ps2_data_d;
    logic            ext_evt;

`ifdef PS2_EXT_KEY_EN
    assign ext_evt = key_ext;
`else
    assign ext_evt = 1'b0;
`endif

    // Bit idx of the 11-bit frame: start, data LSB first, odd parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic [15:0] f;
        f = {5'b11111, ~^b, b, 1'b0};
        return f[idx];
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        bit_d      = bit_q;
        seq_d      = seq_q;
        left_d     = left_q;
        ps2_clk_d  = ps2_clk_q;
        ps2_data_d = ps2_data_q;
        case (state_q)
            StIdle: begin
                cnt_d      = '0;
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                if (key_valid) begin
                    state_d    = StBitHi;
                    bit_d      = '0;
                    ps2_data_d = 1'b0;
                    // seq_q[0] is always the byte on the wire.
                    unique case ({ext_evt, key_release})
                        2'b00: begin seq_d = {8'h00, 8'h00, key_code}; left_d = 2'd1; end
                        2'b01: begin seq_d = {8'h00, key_code, 8'hF0}; left_d = 2'd2; end
                        2'b10: begin seq_d = {8'h00, key_code, 8'hE0}; left_d = 2'd2; end
                        default: begin seq_d = {key_code, 8'hF0, 8'hE0}; left_d = 2'd3; end
                    endcase
                end
            end
            StBitHi: begin
                if (cnt_q == HalfLast) begin
                    state_d   = StBitLo;
                    cnt_d     = '0;
                    ps2_clk_d = 1'b0;
                end
            end
            StBitLo: begin
                if (cnt_q == HalfLast) begin
                    cnt_d     = '0;
                    ps2_clk_d = 1'b1;
                    if (bit_q == 4'd10) begin
                        state_d    = StGap;
                        bit_d      = '0;
                        ps2_data_d = 1'b1;
                    end else begin
                        state_d    = StBitHi;
                        bit_d      = bit_q + 4'd1;
                        ps2_data_d = frame_bit(seq_q[0], bit_q + 4'd1);
                    end
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (left_q > 2'd1) begin
                        state_d    = StBitHi;
                        seq_d      = {8'h00, seq_q[2], seq_q[1]};
                        left_d     = left_q - 2'd1;
                        ps2_data_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                        left_d  = '0;
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                cnt_d      = '0;
                bit_d      = '0;
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            seq_q      <= '0;
            left_q     <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            seq_q      <= seq_d;
            left_q     <= left_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
        end
    end

    assign ps2_clk    = ps2_clk_q;
    assign ps2_data   = ps2_data_q;
    assign key_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StBitLo) && (bit_q == 4'd10) && (cnt_q == HalfLast);

endmodule
